// File: rtl/data_mem_responder.sv
// data_mem_responder: per-channel fixed-latency memory responder with backdoor preload port.
module data_mem_responder #(
  parameter int NUM_CHANNELS  = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 8,
  parameter int LATENCY       = 2,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_CHANNELS-1:0]               mem_read_valid,
  input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]               mem_read_ready,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]    mem_read_data,
  input  logic [NUM_CHANNELS-1:0]               mem_write_valid,
  input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] mem_write_address,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    mem_write_data,
  output logic [NUM_CHANNELS-1:0]               mem_write_ready,
  input  logic                                  load_valid,
  input  logic [ADDRESS_WIDTH-1:0]              load_address,
  input  logic [DATA_WIDTH-1:0]                 load_data
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY + 1) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESPOND, DRAIN} state_t;
  logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];
  logic [NUM_CHANNELS-1:0] commit;
  logic [ADDRESS_WIDTH-1:0] c_addr [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] c_data [NUM_CHANNELS];
  // Channel writes come after the backdoor and in ascending order, so the highest channel wins.
  always_ff @(posedge clk) begin
    if (load_valid) mem[load_address] <= load_data;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (commit[c]) mem[c_addr[c]] <= c_data[c];
  end
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    state_t state, next;
    logic op;
    logic [CW-1:0] cnt;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data, rdata;
    logic rv, wv, accept, done;
    assign rv = mem_read_valid[i];
    assign wv = mem_write_valid[i] && WRITE_ENABLE != 0;
    assign accept = state == IDLE && (rv || wv);
    assign done = state == BUSY && cnt == CW'(1);
    assign commit[i] = done && op;
    assign c_addr[i] = addr;
    assign c_data[i] = data;
    assign mem_read_ready[i] = state == RESPOND && !op;
    assign mem_write_ready[i] = state == RESPOND && op;
    assign mem_read_data[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
    always_comb begin
      next = state == IDLE    ? (accept ? BUSY : IDLE)
           : state == BUSY    ? (done ? RESPOND : BUSY)
           : state == RESPOND ? DRAIN
           : ((op ? wv : rv) ? DRAIN : IDLE);
    end
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= IDLE;
        op <= 1'b0;
        cnt <= '0;
        addr <= '0;
        data <= '0;
        rdata <= '0;
      end else begin
        state <= next;
        if (accept) begin
          op <= !rv;
          cnt <= CW'(LATENCY);
          addr <= rv ? mem_read_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
                     : mem_write_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          data <= mem_write_data[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (state == BUSY) cnt <= cnt - CW'(1);
        if (done && !op) rdata <= mem[addr];
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of the memory responder, with a write-disabled twin instance.
module tb_data_mem_responder;
  logic clk = 0, reset = 1;
  logic [7:0] rv = '0, wv = '0, rr1, wr1, rr2, wr2;
  logic [63:0] ra = '0, wa = '0;
  logic [127:0] wd = '0, rd1, rd2;
  logic load_valid = 0;
  logic [7:0] load_address = '0;
  logic [15:0] load_data = '0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  data_mem_responder dut (
    .clk(clk), .reset(reset),
    .mem_read_valid(rv), .mem_read_address(ra), .mem_read_ready(rr1), .mem_read_data(rd1),
    .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd), .mem_write_ready(wr1),
    .load_valid(load_valid), .load_address(load_address), .load_data(load_data));
  data_mem_responder #(.WRITE_ENABLE(0)) dut_ro (
    .clk(clk), .reset(reset),
    .mem_read_valid(rv), .mem_read_address(ra), .mem_read_ready(rr2), .mem_read_data(rd2),
    .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd), .mem_write_ready(wr2),
    .load_valid(load_valid), .load_address(load_address), .load_data(load_data));
  task automatic load(input logic [7:0] a, input logic [15:0] d);
    load_valid = 1; load_address = a; load_data = d;
    @(negedge clk);
    load_valid = 0;
  endtask
  task automatic settle;
    rv = '0; wv = '0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (rr1 !== 8'h00 || wr1 !== 8'h00) begin failures++; $display("FAIL reset_ready got r=%h w=%h want 00 00", rr1, wr1); end
    checks++; if (rd1 !== 128'h0) begin failures++; $display("FAIL reset_data got %h want 0", rd1); end
    checks++; if (rr2 !== 8'h00 || wr2 !== 8'h00 || rd2 !== 128'h0) begin failures++; $display("FAIL reset_ro got r=%h w=%h d=%h want zeros", rr2, wr2, rd2); end
    reset = 0;
    @(negedge clk);
  endtask
  task automatic test_preload_read;
    load(8'h10, 16'h1234);
    rv[0] = 1; ra[7:0] = 8'h10;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (rr1 !== (k == 3 ? 8'h01 : 8'h00) || wr1 !== 8'h00) begin failures++; $display("FAIL preload_ready cycle %0d got r=%h w=%h want r=%h w=00", k, rr1, wr1, k == 3 ? 8'h01 : 8'h00); end
    end
    checks++; if (rd1[15:0] !== 16'h1234) begin failures++; $display("FAIL preload_data got %h want 1234", rd1[15:0]); end
    rv = '0;
    @(negedge clk);
    checks++; if (rr1 !== 8'h00 || rd1[15:0] !== 16'h1234) begin failures++; $display("FAIL preload_hold got r=%h d=%h want 00 1234", rr1, rd1[15:0]); end
    @(negedge clk);
  endtask
  task automatic test_write_read;
    wv[3] = 1; wa[31:24] = 8'h22; wd[63:48] = 16'hBEEF;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (wr1 !== (k == 3 ? 8'h08 : 8'h00) || rr1 !== 8'h00) begin failures++; $display("FAIL write_ready cycle %0d got w=%h r=%h want w=%h r=00", k, wr1, rr1, k == 3 ? 8'h08 : 8'h00); end
    end
    settle();
    rv[5] = 1; ra[47:40] = 8'h22;
    repeat (3) @(negedge clk);
    checks++; if (rr1 !== 8'h20 || rd1[95:80] !== 16'hBEEF) begin failures++; $display("FAIL write_then_read got r=%h d=%h want 20 beef", rr1, rd1[95:80]); end
    settle();
  endtask
  task automatic test_held_valid;
    int pulses, first, cnt;
    pulses = 0; first = -1;
    rv[1] = 1; ra[15:8] = 8'h10;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (rr1[1]) begin pulses++; if (first < 0) first = k; end
    end
    checks++; if (pulses != 1 || first != 3) begin failures++; $display("FAIL held_single got pulses=%0d first=%0d want 1 3", pulses, first); end
    rv[1] = 0;
    @(negedge clk);
    rv[1] = 1;
    repeat (3) @(negedge clk);
    checks++; if (rr1 !== 8'h02 || rd1[31:16] !== 16'h1234) begin failures++; $display("FAIL held_reraise got r=%h d=%h want 02 1234", rr1, rd1[31:16]); end
    rv[1] = 0;
    repeat (2) @(negedge clk);
    rv[1] = 1; cnt = 2;
    do begin @(negedge clk); cnt++; end while (!rr1[1] && cnt < 12);
    checks++; if (cnt != 5) begin failures++; $display("FAIL held_period got %0d cycles want 5", cnt); end
    settle();
  endtask
  task automatic test_write_conflict;
    wv[2] = 1; wa[23:16] = 8'h30; wd[47:32] = 16'hAAAA;
    wv[6] = 1; wa[55:48] = 8'h30; wd[111:96] = 16'h5555;
    repeat (3) @(negedge clk);
    checks++; if (wr1 !== 8'h44) begin failures++; $display("FAIL conflict_ready got %h want 44", wr1); end
    settle();
    rv[0] = 1; ra[7:0] = 8'h30;
    repeat (3) @(negedge clk);
    checks++; if (rr1 !== 8'h01 || rd1[15:0] !== 16'h5555) begin failures++; $display("FAIL conflict_data got r=%h d=%h want 01 5555", rr1, rd1[15:0]); end
    settle();
  endtask
  task automatic test_concurrency;
    for (int k = 0; k < 8; k++) load(8'h80 + 8'(k), 16'h1000 + 16'(k * 16'h111));
    rv = 8'hFF;
    for (int k = 0; k < 8; k++) ra[k*8 +: 8] = 8'h80 + 8'(k);
    repeat (2) @(negedge clk);
    checks++; if (rr1 !== 8'h00) begin failures++; $display("FAIL concur_early got %h want 00", rr1); end
    @(negedge clk);
    checks++; if (rr1 !== 8'hFF) begin failures++; $display("FAIL concur_ready got %h want ff", rr1); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (rd1[k*16 +: 16] !== 16'h1000 + 16'(k * 16'h111)) begin failures++; $display("FAIL concur_data ch%0d got %h want %h", k, rd1[k*16 +: 16], 16'h1000 + 16'(k * 16'h111)); end
    end
    settle();
  endtask
  task automatic test_reset_midflight;
    int seen;
    seen = 0;
    load(8'h40, 16'h0001);
    wv[4] = 1; wa[39:32] = 8'h40; wd[79:64] = 16'h7777;
    @(negedge clk);
    reset = 1; wv = '0;
    @(negedge clk);
    reset = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rr1 !== 8'h00 || wr1 !== 8'h00) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL reset_no_ready got %0d pulse cycles want 0", seen); end
    checks++; if (rd1 !== 128'h0) begin failures++; $display("FAIL reset_clears_data got %h want 0", rd1); end
    rv[4] = 1; ra[39:32] = 8'h40;
    repeat (3) @(negedge clk);
    checks++; if (rr1 !== 8'h10 || rd1[79:64] !== 16'h0001) begin failures++; $display("FAIL reset_uncommitted got r=%h d=%h want 10 0001", rr1, rd1[79:64]); end
    settle();
  endtask
  task automatic test_write_gating;
    int seen;
    seen = 0;
    load(8'h50, 16'h0042);
    wv[0] = 1; wa[7:0] = 8'h50; wd[15:0] = 16'h9999;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (wr2 !== 8'h00) seen++;
      if (k == 3) begin
        checks++; if (wr1 !== 8'h01) begin failures++; $display("FAIL gating_we1_ready got %h want 01", wr1); end
      end
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL gating_we0_ready got %0d pulse cycles want 0", seen); end
    settle();
    rv[0] = 1; ra[7:0] = 8'h50;
    repeat (3) @(negedge clk);
    checks++; if (rr1[0] !== 1'b1 || rd1[15:0] !== 16'h9999) begin failures++; $display("FAIL gating_we1_data got r=%b d=%h want 1 9999", rr1[0], rd1[15:0]); end
    checks++; if (rr2[0] !== 1'b1 || rd2[15:0] !== 16'h0042) begin failures++; $display("FAIL gating_we0_data got r=%b d=%h want 1 0042", rr2[0], rd2[15:0]); end
    settle();
  endtask
  initial begin
    test_reset();
    test_preload_read();
    test_write_read();
    test_held_valid();
    test_write_conflict();
    test_concurrency();
    test_reset_midflight();
    test_write_gating();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
